// File: rtl/fm_bridge_pkg.sv
// fm_bridge_pkg: bridge FSM state type and CTRL register placement helpers
package fm_bridge_pkg;
  typedef enum logic [1:0] {IDLE, RD_FETCH, RD_DRIVE, WAIT_HI} state_t;
  // CTRL lives at the top of the address space and keeps invert in the data MSB
  function automatic logic [31:0] ctrl_addr(input int aw);
    return (32'd1 << aw) - 32'd1;
  endfunction
  function automatic int ctrl_inv_bit(input int dw);
    return dw - 1;
  endfunction
endpackage

// File: rtl/fm_bus_sync.sv
// fm_bus_sync: W-bit, STAGES-deep flop synchroniser with selectable reset value
// clk_i/rst_i: core clock, sync active-high reset; d_i: async input; q_o: synchronised output
module fm_bus_sync #(
  parameter int W = 1,
  parameter int STAGES = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES-1:0][W-1:0] s_q;
  always_ff @(posedge clk_i)
    if (rst_i) s_q <= {STAGES{RST_VAL}};
    else s_q <= {s_q[STAGES-2:0], d_i};
  assign q_o = s_q[STAGES-1];
endmodule

// File: rtl/fm_bus_bridge.sv
// fm_bus_bridge: async host bus to register strobes, read drive, and sample mute/invert/mix stage
// bus side: ceb_i/rwb_i/addr_i/bus_i in, bus_o/bus_oe_o out
// fm_top side: reg_we_o/reg_re_o strobes, reg_addr_o/reg_wdata_o, reg_rdata_i
// samples: sample_i/sample_vld_i in, sample_o, mix_o/mix_vld_o out
module fm_bus_bridge
  import fm_bridge_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NCH = 4,
  parameter int SAMPLE_W = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               ceb_i,
  input  logic                               rwb_i,
  input  logic [ADDR_W-1:0]                  addr_i,
  input  logic [DATA_W-1:0]                  bus_i,
  output logic [DATA_W-1:0]                  bus_o,
  output logic                               bus_oe_o,
  output logic                               reg_we_o,
  output logic                               reg_re_o,
  output logic [ADDR_W-1:0]                  reg_addr_o,
  output logic [DATA_W-1:0]                  reg_wdata_o,
  input  logic [DATA_W-1:0]                  reg_rdata_i,
  input  logic [NCH*SAMPLE_W-1:0]            sample_i,
  input  logic                               sample_vld_i,
  output logic [NCH*SAMPLE_W-1:0]            sample_o,
  output logic [SAMPLE_W+$clog2(NCH)-1:0]    mix_o,
  output logic                               mix_vld_o
);
  localparam int MIX_W = SAMPLE_W + $clog2(NCH);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_addr(ADDR_W));
  localparam int CTRL_INV_BIT = ctrl_inv_bit(DATA_W);
  logic ceb_s, rwb_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] bus_s;
  fm_bus_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ceb_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(ceb_i), .q_o(ceb_s));
  fm_bus_sync #(.W(ADDR_W+DATA_W+1), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_dat_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i({rwb_i, addr_i, bus_i}), .q_o({rwb_s, addr_s, bus_s}));
  // fill_q marks when ceb_s carries real input instead of reset fill, so a ceb held
  // low through reset release never looks like a falling edge
  logic [SYNC_STAGES-1:0] fill_q;
  logic ceb_d_q, fall_q, rwb_q, we_q, re_q, oe_q, inv_q, we_d, re_d, oe_d, inv_d, ctrl_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, bus_q, bus_d, ctrl_rd;
  logic [NCH-1:0] mute_q, mute_d;
  state_t state_q, state_d;
  logic [NCH*SAMPLE_W-1:0] smp_q, proc_d;
  logic [MIX_W-1:0] mix_q, sum_d;
  logic svld_q, mvld_q;
  wire is_ctrl = addr_q == CTRL_ADDR;
  wire start = state_q == IDLE && fall_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      fill_q <= '0;
      ceb_d_q <= 1'b0;
      fall_q <= 1'b0;
      rwb_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      state_q <= IDLE;
      we_q <= 1'b0;
      re_q <= 1'b0;
      oe_q <= 1'b0;
      bus_q <= '0;
      mute_q <= '0;
      inv_q <= 1'b1;
    end else begin
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      ceb_d_q <= fill_q[SYNC_STAGES-1] & ceb_s;
      fall_q <= ceb_d_q & ~ceb_s;
      if (ceb_d_q && !ceb_s) begin
        rwb_q <= rwb_s;
        addr_q <= addr_s;
        wdata_q <= bus_s;
      end
      state_q <= state_d;
      we_q <= we_d;
      re_q <= re_d;
      oe_q <= oe_d;
      bus_q <= bus_d;
      mute_q <= mute_d;
      inv_q <= inv_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = fall_q ? (rwb_q ? RD_FETCH : WAIT_HI) : IDLE;
      RD_FETCH: state_d = ceb_s ? IDLE : RD_DRIVE;
      RD_DRIVE, WAIT_HI: state_d = ceb_s ? IDLE : state_q;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[NCH-1:0] = mute_q;
    ctrl_rd[CTRL_INV_BIT] = inv_q;
    we_d = start && !rwb_q && !is_ctrl;
    re_d = start && rwb_q && !is_ctrl;
    ctrl_we = start && !rwb_q && is_ctrl;
    bus_d = state_q == RD_FETCH ? (is_ctrl ? ctrl_rd : reg_rdata_i) : bus_q;
    oe_d = (state_q == RD_FETCH || state_q == RD_DRIVE) && !ceb_s;
    mute_d = ctrl_we ? wdata_q[NCH-1:0] : mute_q;
    inv_d = ctrl_we ? wdata_q[CTRL_INV_BIT] : inv_q;
  end
  // inverting an unsigned sample is 2**SAMPLE_W-1 minus it, i.e. a bitwise complement
  always_comb begin
    proc_d = '0;
    sum_d = '0;
    for (int k = 0; k < NCH; k++) begin
      proc_d[k*SAMPLE_W +: SAMPLE_W] = (mute_q[k] ? '0 : sample_i[k*SAMPLE_W +: SAMPLE_W]) ^ {SAMPLE_W{inv_q}};
      sum_d = sum_d + MIX_W'(smp_q[k*SAMPLE_W +: SAMPLE_W]);
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      smp_q <= '0;
      svld_q <= 1'b0;
      mix_q <= '0;
      mvld_q <= 1'b0;
    end else begin
      if (sample_vld_i) smp_q <= proc_d;
      svld_q <= sample_vld_i;
      if (svld_q) mix_q <= sum_d;
      mvld_q <= svld_q;
    end
  assign bus_o = bus_q;
  assign bus_oe_o = oe_q;
  assign reg_we_o = we_q;
  assign reg_re_o = re_q;
  assign reg_addr_o = addr_q;
  assign reg_wdata_o = wdata_q;
  assign sample_o = smp_q;
  assign mix_o = mix_q;
  assign mix_vld_o = mvld_q;
endmodule

// File: tb/tb_fm_bus_bridge.sv
// tb_fm_bus_bridge: scoreboard bench for fm_bus_bridge with default parameters
module tb_fm_bus_bridge;
  typedef struct packed {logic wr; logic [5:0] a; logic [7:0] d;} txn_t;
  localparam logic [5:0] CA = 6'h3F;
  logic clk = 1'b0, rst_i = 1'b1, ceb_i = 1'b1, rwb_i = 1'b0, sample_vld_i = 1'b0;
  logic [5:0] addr_i = '0, reg_addr_o;
  logic [7:0] bus_i = '0, bus_o, reg_wdata_o, reg_rdata_i = '0;
  logic bus_oe_o, reg_we_o, reg_re_o, mix_vld_o;
  logic [47:0] sample_i = '0, sample_o;
  logic [13:0] mix_o;
  int errors = 0, checks = 0, cyc = 0, last_stb = 0, last_oe_rise = 0, stb_cnt = 0;
  logic oe_prev = 1'b0;
  txn_t txq[$];
  logic [7:0] rdq[$];
  logic [47:0] sq[$];
  logic [13:0] mq[$];
  logic [3:0] m_mute = '0;
  logic m_inv = 1'b1;

  fm_bus_bridge dut (
    .clk_i(clk), .rst_i(rst_i), .ceb_i(ceb_i), .rwb_i(rwb_i), .addr_i(addr_i), .bus_i(bus_i),
    .bus_o(bus_o), .bus_oe_o(bus_oe_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
    .sample_i(sample_i), .sample_vld_i(sample_vld_i), .sample_o(sample_o),
    .mix_o(mix_o), .mix_vld_o(mix_vld_o));

  always #5 clk = ~clk;

  function automatic logic [47:0] model_smp(input logic [47:0] x);
    logic [47:0] r;
    logic [11:0] s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = m_mute[k] ? 12'h000 : x[k*12 +: 12];
      r[k*12 +: 12] = m_inv ? 12'hFFF - s : s;
    end
    return r;
  endfunction

  function automatic logic [13:0] model_mix(input logic [47:0] y);
    logic [13:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) m = m + 14'(y[k*12 +: 12]);
    return m;
  endfunction

  task automatic tick();
    txn_t t;
    logic [17:0] got, want;
    logic [7:0] ed;
    logic [47:0] es;
    logic [13:0] em;
    @(negedge clk);
    cyc++;
    if (!rst_i) begin
      if (reg_we_o || reg_re_o) begin
        stb_cnt++;
        last_stb = cyc;
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL strobe: unexpected we=%0b re=%0b addr=%h data=%h", reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o);
        end else begin
          t = txq.pop_front();
          got = {reg_we_o, reg_re_o, reg_addr_o, t.wr ? reg_wdata_o : 8'h00};
          want = {t.wr, ~t.wr, t.a, t.wr ? t.d : 8'h00};
          if (got !== want) begin
            errors++;
            $display("FAIL strobe: got we/re/addr/data %h want %h", got, want);
          end
        end
      end
      if (bus_oe_o && !oe_prev) begin
        last_oe_rise = cyc;
        checks++;
        if (rdq.size() == 0) begin
          errors++;
          $display("FAIL read_oe: unexpected oe with bus_o=%h", bus_o);
        end else begin
          ed = rdq.pop_front();
          if (bus_o !== ed) begin
            errors++;
            $display("FAIL read_data: got %h want %h", bus_o, ed);
          end
        end
      end
      if (mix_vld_o) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL mix: unexpected mix_vld_o mix=%h", mix_o);
        end else begin
          es = sq.pop_front();
          em = mq.pop_front();
          if ({sample_o, mix_o} !== {es, em}) begin
            errors++;
            $display("FAIL mix: got sample=%h mix=%h want sample=%h mix=%h", sample_o, mix_o, es, em);
          end
        end
      end
    end
    oe_prev = bus_oe_o;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    if (a != CA) txq.push_back('{1'b1, a, d});
    addr_i = a;
    bus_i = d;
    rwb_i = 1'b0;
    ceb_i = 1'b0;
    repeat (6) tick();
    ceb_i = 1'b1;
    repeat (4) tick();
    if (a == CA) begin
      m_mute = d[3:0];
      m_inv = d[7];
    end
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [7:0] rdata, input logic [7:0] exp,
                          output logic oe_hold, output logic oe2, output logic oe3);
    if (a != CA) txq.push_back('{1'b0, a, 8'h00});
    rdq.push_back(exp);
    reg_rdata_i = rdata;
    addr_i = a;
    rwb_i = 1'b1;
    ceb_i = 1'b0;
    repeat (8) tick();
    oe_hold = bus_oe_o;
    ceb_i = 1'b1;
    repeat (2) tick();
    oe2 = bus_oe_o;
    tick();
    oe3 = bus_oe_o;
    repeat (2) tick();
  endtask

  task automatic send_samples(input logic [47:0] x);
    logic [47:0] e;
    e = model_smp(x);
    sq.push_back(e);
    mq.push_back(model_mix(e));
    sample_i = x;
    sample_vld_i = 1'b1;
    tick();
    sample_vld_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus_o, bus_oe_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, mix_vld_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got bus=%h oe=%b we=%b re=%b addr=%h wd=%h want all 0", bus_o, bus_oe_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o);
    end
    checks++;
    if ({sample_o, mix_o} !== '0) begin
      errors++;
      $display("FAIL reset_samples: got sample=%h mix=%h want 0", sample_o, mix_o);
    end
    rst_i = 1'b0;
    m_mute = '0;
    m_inv = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_write();
    int s0, t0;
    s0 = stb_cnt;
    t0 = cyc;
    bus_write(6'h05, 8'hA5);
    checks++;
    if (stb_cnt - s0 != 1) begin
      errors++;
      $display("FAIL write_count: got %0d strobes want 1", stb_cnt - s0);
    end
    checks++;
    if (last_stb - t0 != 4) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles want 4", last_stb - t0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = stb_cnt;
    bus_write(6'h2A, 8'h5C);
    bus_write(6'h00, 8'hFF);
    checks++;
    if (stb_cnt - s0 != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes want 2", stb_cnt - s0);
    end
  endtask

  task automatic test_read();
    int s0, t0;
    logic h, o2, o3;
    s0 = stb_cnt;
    t0 = cyc;
    bus_read(6'h10, 8'h3C, 8'h3C, h, o2, o3);
    checks++;
    if (stb_cnt - s0 != 1 || last_stb - t0 != 4) begin
      errors++;
      $display("FAIL read_strobe: got %0d strobes at %0d want 1 at 4", stb_cnt - s0, last_stb - t0);
    end
    checks++;
    if (last_oe_rise - last_stb != 1) begin
      errors++;
      $display("FAIL read_oe_lat: got %0d want 1", last_oe_rise - last_stb);
    end
    checks++;
    if ({h, o2, o3} !== 3'b110) begin
      errors++;
      $display("FAIL read_oe_span: got hold/+2/+3 %b want 110", {h, o2, o3});
    end
  endtask

  task automatic test_ctrl_mute_inv();
    int s0;
    logic h, o2, o3;
    s0 = stb_cnt;
    bus_write(CA, 8'h83);
    send_samples(48'h400_300_200_100);
    checks++;
    if (sample_o !== 48'hBFF_CFF_FFF_FFF || mix_o !== 14'h38FC) begin
      errors++;
      $display("FAIL ctrl_samples: got sample=%h mix=%h want bffcfffffffff 38fc", sample_o, mix_o);
    end
    bus_read(CA, 8'h11, 8'h83, h, o2, o3);
    checks++;
    if (stb_cnt != s0 || h !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_local: got %0d strobes oe=%b want 0 strobes oe=1", stb_cnt - s0, h);
    end
  endtask

  task automatic test_ctrl_zero();
    logic [47:0] e;
    bus_write(CA, 8'h00);
    e = model_smp(48'hFFF_FFF_FFF_FFF);
    sq.push_back(e);
    mq.push_back(model_mix(e));
    sample_i = 48'hFFF_FFF_FFF_FFF;
    sample_vld_i = 1'b1;
    tick();
    sample_vld_i = 1'b0;
    checks++;
    if (sample_o !== 48'hFFF_FFF_FFF_FFF || mix_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_stage1: got sample=%h vld=%b want all fff vld=0", sample_o, mix_vld_o);
    end
    tick();
    checks++;
    if (mix_vld_o !== 1'b1 || mix_o !== 14'h3FFC) begin
      errors++;
      $display("FAIL zero_mix: got vld=%b mix=%h want 1 3ffc", mix_vld_o, mix_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_same_cycle();
    logic [47:0] e;
    addr_i = CA;
    bus_i = 8'h8F;
    rwb_i = 1'b0;
    ceb_i = 1'b0;
    repeat (3) tick();
    e = model_smp(48'h123_456_789_ABC);
    sq.push_back(e);
    mq.push_back(model_mix(e));
    sample_i = 48'h123_456_789_ABC;
    sample_vld_i = 1'b1;
    tick();
    sample_vld_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (sample_o !== 48'h123_456_789_ABC) begin
      errors++;
      $display("FAIL same_cycle: got %h want %h", sample_o, 48'h123_456_789_ABC);
    end
    ceb_i = 1'b1;
    repeat (4) tick();
    m_mute = 4'hF;
    m_inv = 1'b1;
    send_samples(48'h123_456_789_ABC);
  endtask

  task automatic test_abort();
    int s0, t0, bad;
    s0 = stb_cnt;
    bad = 0;
    txq.push_back('{1'b0, 6'h10, 8'h00});
    txq.push_back('{1'b0, 6'h10, 8'h00});
    rdq.push_back(8'h5A);
    reg_rdata_i = 8'h5A;
    addr_i = 6'h10;
    rwb_i = 1'b1;
    ceb_i = 1'b0;
    t0 = cyc;
    repeat (2) tick();
    ceb_i = 1'b1;
    tick();
    ceb_i = 1'b0;
    repeat (4) begin
      tick();
      if (bus_oe_o) bad++;
    end
    tick();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_oe: got %0d cycles with oe want 0", bad);
    end
    tick();
    checks++;
    if (last_oe_rise - t0 != 8 || stb_cnt - s0 != 2) begin
      errors++;
      $display("FAIL abort_recover: got oe at %0d strobes %0d want 8 and 2", last_oe_rise - t0, stb_cnt - s0);
    end
    ceb_i = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset_low();
    int s0;
    rst_i = 1'b1;
    ceb_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    m_mute = '0;
    m_inv = 1'b1;
    s0 = stb_cnt;
    repeat (10) tick();
    checks++;
    if (stb_cnt != s0 || bus_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_low: got %0d strobes oe=%b want 0 0", stb_cnt - s0, bus_oe_o);
    end
    ceb_i = 1'b1;
    repeat (4) tick();
    s0 = stb_cnt;
    bus_write(6'h05, 8'h66);
    checks++;
    if (stb_cnt - s0 != 1) begin
      errors++;
      $display("FAIL reset_low_after: got %0d strobes want 1", stb_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    logic h, o2, o3;
    txq.push_back('{1'b0, 6'h20, 8'h00});
    rdq.push_back(8'h77);
    reg_rdata_i = 8'h77;
    addr_i = 6'h20;
    rwb_i = 1'b1;
    ceb_i = 1'b0;
    repeat (7) tick();
    checks++;
    if (bus_oe_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_drive: got oe=%b want 1", bus_oe_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if ({bus_oe_o, reg_re_o, bus_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got oe=%b re=%b bus=%h want 0", bus_oe_o, reg_re_o, bus_o);
    end
    rst_i = 1'b0;
    ceb_i = 1'b1;
    m_mute = '0;
    m_inv = 1'b1;
    repeat (4) tick();
    bus_read(CA, 8'h00, 8'h80, h, o2, o3);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL mid_ctrl_read: got oe=%b want 1", h);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_ctrl_mute_inv();
    test_ctrl_zero();
    test_same_cycle();
    test_abort();
    test_reset_low();
    test_reset_mid();
    repeat (4) tick();
    checks++;
    if (txq.size() + rdq.size() + sq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d/%0d pending want 0", txq.size(), rdq.size(), sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
